// File: rtl/phase_seq.sv
// Upstream phase sequencer for the junction yellow/green controller.
// Every output is a flop so the downstream rising-edge detectors never see glitches.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_START  | single cycle after reset, all outputs low
// ST_J      | junction-road phase, J=1
// ST_P      | pedestrian / all-stop phase, P=1
// ST_C      | cross-road phase, C=1
// ST_NIGHT  | night flash, J=C=N=1, left only on a tick
// ST_ALLRED | all outputs low for T_AR, then back to ST_J
module phase_seq #(
    parameter int UCY   = 1000,
    parameter int L     = 10,
    parameter int S     = 3,
    parameter int GUARD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ped_req,
    input  logic night_req,
    output logic J,
    output logic P,
    output logic C,
    output logic N,
    output logic ped_ack,
    output logic tick
);

    localparam int PW = (UCY > 1) ? $clog2(UCY) : 1;
    localparam int UW = $clog2(L + 2 * S + GUARD + 1);

    localparam logic [PW-1:0] PRE_MAX = PW'(UCY - 1);
    localparam logic [UW-1:0] TJ_M1   = UW'(L + S + GUARD - 1);
    localparam logic [UW-1:0] TPL_M1  = UW'(L - S - 1);
    localparam logic [UW-1:0] TPS_M1  = UW'(S - 1);
    localparam logic [UW-1:0] TC_M1   = UW'(L + 2 * S + GUARD - 1);
    localparam logic [UW-1:0] TAR_M1  = UW'(S - 1);

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_J      = 3'd1,
        ST_P      = 3'd2,
        ST_C      = 3'd3,
        ST_NIGHT  = 3'd4,
        ST_ALLRED = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [UW-1:0]   unit_q, unit_d;
    logic            ped_pend_q, ped_pend_d;
    logic            tp_long_q, tp_long_d;
    logic            j_q, j_d;
    logic            p_q, p_d;
    logic            c_q, c_d;
    logic            n_q, n_d;
    logic            ack_q, ack_d;
    logic            tick_q, tick_d;

    logic            tick_w;
    logic [UW-1:0]   len_m1;
    logic            phase_end;
    logic            state_chg;
    logic            p_entry;
    logic            night_entry;
    logic            ped_accept;

    assign tick_w = (pre_q == PRE_MAX);

    always_comb begin
        len_m1 = TJ_M1;
        case (state_q)
            ST_J:      len_m1 = TJ_M1;
            ST_P:      len_m1 = tp_long_q ? TPL_M1 : TPS_M1;
            ST_C:      len_m1 = TC_M1;
            ST_ALLRED: len_m1 = TAR_M1;
            default:   len_m1 = TJ_M1;
        endcase
    end

    assign phase_end = tick_w && (unit_q == len_m1);

    // State register: every flop of the block, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_START;
            pre_q      <= '0;
            unit_q     <= '0;
            ped_pend_q <= 1'b0;
            tp_long_q  <= 1'b0;
            j_q        <= 1'b0;
            p_q        <= 1'b0;
            c_q        <= 1'b0;
            n_q        <= 1'b0;
            ack_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            unit_q     <= unit_d;
            ped_pend_q <= ped_pend_d;
            tp_long_q  <= tp_long_d;
            j_q        <= j_d;
            p_q        <= p_d;
            c_q        <= c_d;
            n_q        <= n_d;
            ack_q      <= ack_d;
            tick_q     <= tick_d;
        end
    end

    // Night request outranks the normal successor at every phase end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START: state_d = ST_J;
            ST_J: begin
                if (phase_end) state_d = night_req ? ST_NIGHT : ST_P;
            end
            ST_P: begin
                if (phase_end) state_d = night_req ? ST_NIGHT : ST_C;
            end
            ST_C: begin
                if (phase_end) state_d = night_req ? ST_NIGHT : ST_J;
            end
            ST_NIGHT: begin
                if (tick_w && !night_req) state_d = ST_ALLRED;
            end
            ST_ALLRED: begin
                if (phase_end) state_d = night_req ? ST_NIGHT : ST_J;
            end
            default: state_d = ST_START;
        endcase
    end

    always_comb begin
        state_chg   = (state_d != state_q);
        p_entry     = (state_d == ST_P) && (state_q != ST_P);
        night_entry = (state_d == ST_NIGHT) && (state_q != ST_NIGHT);
        ped_accept  = ped_req && (state_q != ST_NIGHT) && (state_q != ST_ALLRED);

        pre_d = pre_q;
        if (state_chg) begin
            pre_d = '0;
        end else if (tick_w) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PW'(1);
        end

        // Night waits on the tick alone, so the unit count is parked there.
        unit_d = unit_q;
        if (state_chg) begin
            unit_d = '0;
        end else if (tick_w && (state_q != ST_NIGHT)) begin
            unit_d = unit_q + UW'(1);
        end

        tick_d = (pre_d == PRE_MAX);

        tp_long_d = p_entry ? ped_pend_q : tp_long_q;

        ped_pend_d = ped_pend_q;
        if (p_entry) ped_pend_d = 1'b0;
        if (ped_accept) ped_pend_d = 1'b1;
        if (night_entry) ped_pend_d = 1'b0;
    end

    always_comb begin
        j_d   = 1'b0;
        p_d   = 1'b0;
        c_d   = 1'b0;
        n_d   = 1'b0;
        ack_d = p_entry && ped_pend_q;
        case (state_d)
            ST_J:     j_d = 1'b1;
            ST_P:     p_d = 1'b1;
            ST_C:     c_d = 1'b1;
            ST_NIGHT: begin
                j_d = 1'b1;
                c_d = 1'b1;
                n_d = 1'b1;
            end
            default: begin
                j_d = 1'b0;
                p_d = 1'b0;
                c_d = 1'b0;
                n_d = 1'b0;
            end
        endcase
    end

    assign J       = j_q;
    assign P       = p_q;
    assign C       = c_q;
    assign N       = n_q;
    assign ped_ack = ack_q;
    assign tick    = tick_q;

    a_p_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(P && (J || C)));
    a_n_is_night: assert property (@(posedge clk) disable iff (!rst)
        N == (state_q == ST_NIGHT));
    a_one_phase: assert property (@(posedge clk) disable iff (!rst)
        ((state_q == ST_J) || (state_q == ST_P) || (state_q == ST_C)) |-> $onehot({J, P, C}));
    a_ack_in_p: assert property (@(posedge clk) disable iff (!rst)
        ped_ack |-> P);

endmodule
